// File: rtl/adder_pkg.sv
// Operation encodings for the pipelined adder/subtractor, shared with the bench.
package adder_pkg;
  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;
endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the ripple slices.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/pipelined_addsub_chunk.sv
// CHUNK-bit combinational ripple slice; c_msb is the carry into the slice MSB.
module add_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);
  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: one CHUNK-bit ripple slice per stage,
// carry and unconsumed operand slices registered between stages, valid/ready on both sides.
module pipelined_addsub
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             subEn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);
  localparam int unsigned STAGES = WIDTH / CHUNK;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("pipelined_addsub: WIDTH must be a multiple of CHUNK");
  end

  logic adv;

  // Stage inputs: stage 0 reads the ports, stage k reads rank k-1 registers.
  logic [WIDTH-1:0] op_a [STAGES];
  logic [WIDTH-1:0] op_b [STAGES];
  logic [WIDTH-1:0] op_s [STAGES];
  logic             op_c [STAGES];
  logic             op_v [STAGES];

  logic [CHUNK-1:0] cs [STAGES];
  logic             co [STAGES];
  logic             cm [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];

  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];
  logic             ovf_q;
  logic             zero_q;

  assign adv      = !v_q[STAGES-1] || out_ready;
  assign in_ready = adv;

  always_comb begin
    op_a[0] = a;
    op_b[0] = b ^ {WIDTH{subEn}};
    op_c[0] = (subEn == SUB);
    op_s[0] = '0;
    op_v[0] = in_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      op_a[k] = a_q[k-1];
      op_b[k] = b_q[k-1];
      op_c[k] = c_q[k-1];
      op_s[k] = s_q[k-1];
      op_v[k] = v_q[k-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    add_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a     (op_a[g][g*CHUNK +: CHUNK]),
      .b     (op_b[g][g*CHUNK +: CHUNK]),
      .cin   (op_c[g]),
      .sum   (cs[g]),
      .cout  (co[g]),
      .c_msb (cm[g])
    );
  end

  // Each stage drops its finished slice into the de-skewed partial result.
  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      s_d[k] = op_s[k];
      s_d[k][k*CHUNK +: CHUNK] = cs[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= op_a[k];
        b_q[k] <= op_b[k];
        s_q[k] <= s_d[k];
        c_q[k] <= co[k];
        v_q[k] <= op_v[k];
      end
      ovf_q  <= cm[STAGES-1] ^ co[STAGES-1];
      zero_q <= (s_d[STAGES-1] == '0);
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign result    = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign overflow  = ovf_q;
  assign zero      = zero_q;
endmodule
